// File: rtl/sar_adc_responder_if.sv
// Purpose: soc/eoc start-of-conversion handshake plus the DAC/comparator pair.
// Latency: none. This is wiring only.
// Backpressure: the consumer holds soc high until eoc drops. soc is honoured only while eoc is high.
// Signals:
//   soc    - start of conversion, driven by the consumer
//   eoc    - end of conversion; high means idle and numero is valid
//   numero - last conversion result
//   dac    - trial code sent to the external DAC
//   cmp    - comparator bit; 1 when the analog input is >= dac
interface sar_adc_responder_if #(
  parameter int N = 8
);
  logic         soc;
  logic         eoc;
  logic [N-1:0] numero;
  logic [N-1:0] dac;
  logic         cmp;

  // Consumer side, which includes the analog front end that returns cmp.
  modport master (
    output soc,
    output cmp,
    input  eoc,
    input  numero,
    input  dac
  );

  // Converter side.
  modport slave (
    input  soc,
    input  cmp,
    output eoc,
    output numero,
    output dac
  );
endinterface

// File: rtl/sar_adc_responder.sv
// Purpose: N-bit successive-approximation converter controller, answering soc/eoc.
// Latency: the result lands N*SETTLE edges after soc is released, and eoc rises one edge later.
// Backpressure: soc held high parks the block in ACK. soc is ignored outside IDLE.
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-high; aborts any conversion in progress
//   bus   - slave side of sar_adc_responder_if (soc, cmp in; eoc, numero, dac out)
module sar_adc_responder #(
  parameter int N      = 8,
  parameter int SETTLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  sar_adc_responder_if.slave    bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    CONV = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            eoc_q, eoc_d;
  logic [N-1:0]    numero_q, numero_d;
  logic [N-1:0]    dac_q, dac_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Trial code after the current bit has been kept or cleared.
  logic [N-1:0]    decided;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      eoc_q    <= 1'b1;
      numero_q <= '0;
      dac_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      eoc_q    <= eoc_d;
      numero_q <= numero_d;
      dac_q    <= dac_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    eoc_d    = eoc_q;
    numero_d = numero_q;
    dac_d    = dac_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;

    decided  = dac_q;
    if (!bus.cmp) begin
      decided[idx_q] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.soc) begin
          eoc_d   = 1'b0;
          state_d = ACK;
        end
      end

      ACK: begin
        // Wait until the consumer drops soc, so that one request gives one conversion.
        if (!bus.soc) begin
          dac_d        = '0;
          dac_d[N-1]   = 1'b1;
          idx_d        = IW'(N - 1);
          cnt_d        = CW'(SETTLE - 1);
          state_d      = CONV;
        end
      end

      CONV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (idx_q != '0) begin
          dac_d                  = decided;
          dac_d[idx_q - IW'(1)]  = 1'b1;
          idx_d                  = idx_q - IW'(1);
          cnt_d                  = CW'(SETTLE - 1);
        end else begin
          dac_d    = decided;
          numero_d = decided;
          state_d  = FIN;
        end
      end

      FIN: begin
        // numero was written on the previous edge and has settled before eoc rises.
        eoc_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.eoc    = eoc_q;
  assign bus.numero = numero_q;
  assign bus.dac    = dac_q;

endmodule

// File: tb/tb_sar_adc_responder.sv
module tb_sar_adc_responder;

  logic clock;
  logic reset;
  logic [7:0] analog1;
  logic [7:0] analog3;

  int n_checks;
  int n_fail;

  // Reference model: the expected trial sequence and result for one analog value.
  logic [7:0] trial [8];
  logic [7:0] exp_res;
  // What the bench expects the first DUT to be holding between conversions.
  logic [7:0] model_numero;
  logic [7:0] model_dac;

  sar_adc_responder_if #(.N(8)) ifc1 ();
  sar_adc_responder_if #(.N(8)) ifc3 ();

  sar_adc_responder #(.N(8), .SETTLE(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc1.slave)
  );

  sar_adc_responder #(.N(8), .SETTLE(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc3.slave)
  );

  // Ideal comparators.
  assign ifc1.cmp = (analog1 >= ifc1.dac);
  assign ifc3.cmp = (analog3 >= ifc3.dac);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Binary search over codes: try each bit from the MSB down and keep it if the input is at or above the trial.
  function automatic void build_model(input logic [7:0] analog);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      t = r | (8'h01 << b);
      trial[7 - b] = t;
      if (analog >= t) r = t;
    end
    exp_res = r;
  endfunction

  // Runs a conversion on the SETTLE=1 instance. Call it at a negedge. soc rises
  // at once, so calling this right after eoc rises tests back-to-back requests.
  task automatic conv1(input logic [7:0] analog, input int hold, input bit repulse);
    build_model(analog);
    analog1   = analog;
    ifc1.soc  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      n_checks++;
      if (ifc1.eoc !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_eoc: eoc=%b required 0 (hold cycle %0d)", ifc1.eoc, h);
      end
      n_checks++;
      if (ifc1.dac !== model_dac) begin
        n_fail++;
        $display("FAIL ack_dac_stable: dac=%h required %h", ifc1.dac, model_dac);
      end
    end
    ifc1.soc = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      n_checks++;
      if (ifc1.dac !== trial[c]) begin
        n_fail++;
        $display("FAIL trial: analog=%h step %0d dac=%h required %h", analog, c, ifc1.dac, trial[c]);
      end
      n_checks++;
      if (ifc1.eoc !== 1'b0 || ifc1.numero !== model_numero) begin
        n_fail++;
        $display("FAIL conv_hold: eoc=%b numero=%h required eoc=0 numero=%h",
                 ifc1.eoc, ifc1.numero, model_numero);
      end
      if (repulse) ifc1.soc = (c == 3);
    end
    ifc1.soc = 1'b0;
    @(negedge clock);
    n_checks++;
    if (ifc1.numero !== exp_res || ifc1.eoc !== 1'b0) begin
      n_fail++;
      $display("FAIL result_early: numero=%h eoc=%b required numero=%h eoc=0",
               ifc1.numero, ifc1.eoc, exp_res);
    end
    @(negedge clock);
    n_checks++;
    if (ifc1.eoc !== 1'b1 || ifc1.numero !== exp_res || ifc1.dac !== exp_res) begin
      n_fail++;
      $display("FAIL eoc_rise: eoc=%b numero=%h dac=%h required eoc=1 numero=dac=%h",
               ifc1.eoc, ifc1.numero, ifc1.dac, exp_res);
    end
    model_numero = exp_res;
    model_dac    = exp_res;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    ifc1.soc = 1'b0;
    ifc3.soc = 1'b0;
    analog1  = 8'h00;
    analog3  = 8'h00;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (ifc1.eoc !== 1'b1 || ifc1.numero !== 8'h00 || ifc1.dac !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: eoc=%b numero=%h dac=%h required 1/00/00",
               ifc1.eoc, ifc1.numero, ifc1.dac);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    model_numero = 8'h00;
    model_dac    = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_checks++;
      if (ifc1.eoc !== 1'b1 || ifc1.numero !== 8'h00 || ifc1.dac !== 8'h00 ||
          ifc3.eoc !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_stable: cycle %0d eoc=%b numero=%h dac=%h required 1/00/00",
                 i, ifc1.eoc, ifc1.numero, ifc1.dac);
      end
    end
  endtask

  task automatic test_nominal();
    conv1(8'hA5, 1, 1'b0);
  endtask

  task automatic test_extremes();
    conv1(8'h00, 1, 1'b0);
    conv1(8'hFF, 1, 1'b0);
    conv1(8'h80, 1, 1'b0);
  endtask

  // conv1 returns at the negedge where eoc is first high, so each next call raises soc with no idle gap.
  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      conv1(8'($urandom_range(0, 255)), 1, 1'b0);
    end
  endtask

  task automatic test_handshake_abuse();
    @(negedge clock);
    conv1(8'($urandom_range(0, 255)), 10, 1'b0);
    @(negedge clock);
    conv1(8'($urandom_range(0, 255)), 1, 1'b1);
    // The soc pulse during CONV must not have queued a second conversion.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      n_checks++;
      if (ifc1.eoc !== 1'b1 || ifc1.numero !== model_numero) begin
        n_fail++;
        $display("FAIL repulse_ignored: cycle %0d eoc=%b numero=%h required 1/%h",
                 i, ifc1.eoc, ifc1.numero, model_numero);
      end
    end
  endtask

  task automatic test_settle3();
    build_model(8'h3C);
    analog3  = 8'h3C;
    @(negedge clock);
    ifc3.soc = 1'b1;
    @(negedge clock);
    n_checks++;
    if (ifc3.eoc !== 1'b0) begin
      n_fail++;
      $display("FAIL s3_ack: eoc=%b required 0", ifc3.eoc);
    end
    ifc3.soc = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      n_checks++;
      if (ifc3.dac !== trial[c / 3] || ifc3.eoc !== 1'b0) begin
        n_fail++;
        $display("FAIL s3_trial: cycle %0d dac=%h eoc=%b required dac=%h eoc=0",
                 c, ifc3.dac, ifc3.eoc, trial[c / 3]);
      end
    end
    @(negedge clock);
    n_checks++;
    if (ifc3.numero !== 8'h3C || ifc3.eoc !== 1'b0) begin
      n_fail++;
      $display("FAIL s3_result: numero=%h eoc=%b required 3c/0", ifc3.numero, ifc3.eoc);
    end
    @(negedge clock);
    n_checks++;
    if (ifc3.eoc !== 1'b1) begin
      n_fail++;
      $display("FAIL s3_eoc: eoc=%b required 1 at 25 cycles", ifc3.eoc);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      conv1(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    build_model(8'hC3);
    analog1  = 8'hC3;
    @(negedge clock);
    ifc1.soc = 1'b1;
    @(negedge clock);
    ifc1.soc = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (ifc1.eoc !== 1'b1 || ifc1.numero !== 8'h00 || ifc1.dac !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: eoc=%b numero=%h dac=%h required 1/00/00",
               ifc1.eoc, ifc1.numero, ifc1.dac);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    model_numero = 8'h00;
    model_dac    = 8'h00;
    @(negedge clock);
    n_checks++;
    if (ifc1.eoc !== 1'b1 || ifc1.numero !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_idle: eoc=%b numero=%h required 1/00", ifc1.eoc, ifc1.numero);
    end
    conv1(8'h5A, 1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_nominal();
    test_extremes();
    test_back_to_back();
    test_handshake_abuse();
    test_settle3();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
